arb_burst_mux: RTL
==================

ARB_BURST_MUX -- requirements
Module: arb_burst_mux

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, the number of requesters (legal range 2..64).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8, the beat payload width.
REQ-003 The module SHALL have parameter MAX_BEATS, default 16, the burst beat limit used only under ARB_BURST_LIMIT_EN (legal range ≥1).
REQ-004 The module SHALL have the following ports (name, direction, width, meaning):
- clk_i, input, 1: the single clock.
- arst_ni, input, 1: reset; asynchronous, active-low.
- req_valid_i, input, NUM_REQ: per-requester beat valid.
- req_data_i, input, NUM_REQ*DATA_WIDTH: payloads; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_last_i, input, NUM_REQ: per-requester last beat of burst.
- req_ready_o, output, NUM_REQ: per-requester beat accepted.
- out_valid_o, output, 1: downstream beat valid.
- out_data_o, output, DATA_WIDTH: downstream payload.
- out_last_o, output, 1: downstream last beat.
- out_id_o, output, $clog2(NUM_REQ): index of the granted requester.
- out_ready_i, input, 1: downstream ready.

Function
REQ-005 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-006 In IDLE, out_valid_o and all req_ready_o bits SHALL be 0.
REQ-007 In IDLE with any req_valid_i bit set, the block SHALL register as gnt_id the first set index strictly after last_gnt, searching upward modulo NUM_REQ, and SHALL enter BURST on the next edge.
REQ-008 In IDLE with no request, the block SHALL remain in IDLE with gnt_id unchanged.
REQ-009 In BURST, the outputs SHALL be driven combinationally from the granted requester:
- out_valid_o = req_valid_i[gnt_id]
- out_data_o = slice gnt_id of req_data_i
- out_last_o = req_last_i[gnt_id]
- out_id_o = gnt_id
REQ-010 In BURST, req_ready_o[gnt_id] SHALL equal out_ready_i, and every other req_ready_o bit SHALL be 0.
REQ-011 A beat SHALL transfer exactly on a cycle with out_valid_o && out_ready_i.
REQ-012 On a transferred beat with out_last_o=1, last_gnt SHALL take the value gnt_id and the FSM SHALL return to IDLE.
REQ-013 Consecutive bursts SHALL be separated by exactly one IDLE cycle; the first beat of a burst SHALL be presentable one cycle after its request is sampled in IDLE.
REQ-014 If the granted requester deasserts valid mid-burst, the grant SHALL be held, with out_valid_o=0, until that requester's last beat transfers.
REQ-015 Requests from non-granted requesters SHALL NOT affect the grant while in BURST.
REQ-016 With a single active requester, that requester SHALL be re-granted after each one-cycle IDLE gap.
REQ-017 A requester asserting valid with last=1 on its first beat SHALL complete a one-beat burst.

Reset
REQ-018 While arst_ni=0, the block SHALL force: FSM=IDLE, gnt_id=0, last_gnt=NUM_REQ-1 (so requester 0 has first priority), beat counter=0, out_valid_o=0, and req_ready_o=0.
REQ-019 During reset, out_data_o, out_last_o and out_id_o SHALL reflect gnt_id=0 gated by IDLE, i.e. out_last_o=0 and out_id_o=0.
REQ-020 Reset asserted mid-burst SHALL abandon the burst immediately with no further beats, and arbitration SHALL restart from requester 0 after release.

Configuration
REQ-021 With macro ARB_BURST_LIMIT_EN defined, a beat counter SHALL count transferred beats in BURST.
REQ-022 With ARB_BURST_LIMIT_EN defined, when the MAX_BEATS-th beat transfers, the FSM SHALL return to IDLE and set last_gnt=gnt_id as if last had been seen; out_last_o SHALL be forced to 1 on that beat.
REQ-023 With ARB_BURST_LIMIT_EN defined, the counter SHALL clear on every return to IDLE.
REQ-024 Without ARB_BURST_LIMIT_EN, no counter SHALL exist, MAX_BEATS SHALL be ignored, and bursts SHALL end only on req_last_i.

Verification (NUM_REQ=4, DATA_WIDTH=8, MAX_BEATS=4)
REQ-025 Release reset with req_valid_i=4'b1111, all last=1, out_ready_i=1 -> out_id_o SHALL sequence 0,1,2,3,0 on successive BURST cycles, with one IDLE cycle between each.
REQ-026 Requester 2 sends a 3-beat burst 0xA1, 0xA2, 0xA3 (last on 0xA3) while requester 1 requests throughout -> out_data_o SHALL be A1, A2, A3 uninterrupted, and requester 1 SHALL be granted next.
REQ-027 During a burst, hold out_ready_i=0 for 5 cycles -> out_data_o SHALL be stable, req_ready_o SHALL be 0, and no beat SHALL be lost.
REQ-028 Assert arst_ni=0 on the 2nd beat of a requester-3 burst -> out_valid_o SHALL be 0 that cycle, and after release with requests 4'b1010 the first grant SHALL be to requester 1.
REQ-029 With ARB_BURST_LIMIT_EN defined, requester 0 sends 6 beats with no last while requester 1 is waiting -> beat 4 SHALL show out_last_o=1, then requester 1 SHALL be granted, then requester 0 SHALL resume with its 5th beat.
REQ-030 Granted requester 1 drops valid for 3 cycles mid-burst while requester 0 is requesting -> out_id_o SHALL stay 1 with out_valid_o=0 until requester 1's last beat.

Source files
------------

// File: rtl/arb_burst_mux.sv
// -----------------------------------------------------------------------------
// arb_burst_mux
//
// Round-robin burst arbiter and multiplexer. NUM_REQ requesters each offer a
// stream of beats (valid/data/last). Once a requester is granted, it owns the
// downstream port until its last beat transfers. The output is a single
// valid/ready stream tagged with the index of the granted requester.
//
// Grants are issued only from the IDLE state, so consecutive bursts are always
// separated by exactly one IDLE cycle. The search starts one position after
// the most recently completed grant and wraps modulo NUM_REQ. After reset,
// requester 0 has first priority.
//
// Optional feature (compile-time macro ARB_BURST_LIMIT_EN):
//   When defined, a beat counter caps each burst at MAX_BEATS transferred
//   beats. The MAX_BEATS-th beat is presented with out_last_o forced high and
//   ends the burst exactly as a real last beat would. When the macro is not
//   defined there is no counter, MAX_BEATS has no effect, and bursts end only
//   on req_last_i.
//
// Parameters:
//   NUM_REQ    - number of requesters (2..64)
//   DATA_WIDTH - beat payload width
//   MAX_BEATS  - burst beat limit, used only with ARB_BURST_LIMIT_EN (>= 1)
//
// Ports:
//   clk_i        in   1                    clock
//   arst_ni      in   1                    asynchronous active-low reset
//   req_valid_i  in   NUM_REQ              per-requester beat valid
//   req_data_i   in   NUM_REQ*DATA_WIDTH   payloads, requester k at
//                                          [k*DATA_WIDTH +: DATA_WIDTH]
//   req_last_i   in   NUM_REQ              per-requester last beat of burst
//   req_ready_o  out  NUM_REQ              per-requester beat accepted
//   out_valid_o  out  1                    downstream beat valid
//   out_data_o   out  DATA_WIDTH           downstream payload
//   out_last_o   out  1                    downstream last beat
//   out_id_o     out  $clog2(NUM_REQ)      index of granted requester
//   out_ready_i  in   1                    downstream ready
// -----------------------------------------------------------------------------
module arb_burst_mux #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BEATS  = 16
) (
    input  logic                          clk_i,
    input  logic                          arst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          out_valid_o,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic                          out_last_o,
    output logic [$clog2(NUM_REQ)-1:0]    out_id_o,
    input  logic                          out_ready_i
);

    localparam int ID_W = $clog2(NUM_REQ);

    // FSM encoding
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    // Elaboration-time range guards. An out-of-range parameter produces an
    // empty, clearly named scope in the elaborated hierarchy so it is easy to
    // spot in a netlist or hierarchy browser.
    if (NUM_REQ < 2 || NUM_REQ > 64) begin : g_num_req_out_of_range
    end
    if (MAX_BEATS < 1) begin : g_max_beats_out_of_range
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]      state_reg,    state_next;
    logic [ID_W-1:0] gnt_id_reg,   gnt_id_next;
    logic [ID_W-1:0] last_gnt_reg, last_gnt_next;

    logic            burst_active;
    logic            beat_xfer;
    logic            burst_end;
    logic            limit_hit;

    assign burst_active = (state_reg == BURST);

    // -------------------------------------------------------------------------
    // Unpack the flat payload bus into per-requester slices
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_data_arr[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // -------------------------------------------------------------------------
    // Round-robin pick: first requester strictly after last_gnt, wrapping.
    // The loop walks offsets from farthest to nearest so that the nearest
    // valid requester is the final (winning) assignment.
    // -------------------------------------------------------------------------
    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    logic [ID_W-1:0] pick_id;
    logic            any_req;
    logic [ID_W:0]   cand_idx;

    always_comb begin
        pick_id  = gnt_id_reg;
        any_req  = |req_valid_i;
        cand_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            // One extra bit holds last_gnt + i (at most 2*NUM_REQ-1)
            // before the single conditional wrap.
            cand_idx = {1'b0, last_gnt_reg} + (ID_W+1)'(i);
            if (cand_idx >= NUM_REQ_W) begin
                cand_idx = cand_idx - NUM_REQ_W;
            end
            if (req_valid_i[cand_idx[ID_W-1:0]]) begin
                pick_id = cand_idx[ID_W-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output multiplexer. Everything is gated by BURST so that IDLE (and
    // reset) presents a quiet port: no valid, no last, id 0, data 0.
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        out_id_o    = '0;
        if (burst_active) begin
            out_valid_o = req_valid_i[gnt_id_reg];
            out_data_o  = req_data_arr[gnt_id_reg];
            // The limit forces a synthetic last on the capping beat.
            out_last_o  = req_last_i[gnt_id_reg] | limit_hit;
            out_id_o    = gnt_id_reg;
        end
    end

    // Only the granted requester sees downstream ready; the others are held
    // off so their beats stay queued at the source.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready_o[gi] = burst_active
                              && (gnt_id_reg == ID_W'(gi))
                              && out_ready_i;
    end

    assign beat_xfer = out_valid_o & out_ready_i;
    assign burst_end = burst_active & beat_xfer & out_last_o;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        gnt_id_next   = gnt_id_reg;
        last_gnt_next = last_gnt_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    gnt_id_next = pick_id;
                    state_next  = BURST;
                end
            end
            BURST: begin
                // Holding the grant while the owner is stalled or has
                // dropped valid is implicit: only a final beat leaves BURST.
                if (burst_end) begin
                    last_gnt_next = gnt_id_reg;
                    state_next    = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_reg    <= IDLE;
            gnt_id_reg   <= '0;
            // Start "after" the top index so requester 0 wins first.
            last_gnt_reg <= ID_W'(NUM_REQ-1);
        end else begin
            state_reg    <= state_next;
            gnt_id_reg   <= gnt_id_next;
            last_gnt_reg <= last_gnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Optional burst-length limit
    // -------------------------------------------------------------------------
`ifdef ARB_BURST_LIMIT_EN
    localparam int CNT_W = (MAX_BEATS < 2) ? 1 : $clog2(MAX_BEATS);

    // Counts beats already transferred in the current burst; the beat being
    // presented is number beat_cnt_reg+1, so the limit is reached when the
    // counter sits at MAX_BEATS-1.
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

    assign limit_hit = (beat_cnt_reg == CNT_W'(MAX_BEATS-1));

    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        if (!burst_active || burst_end) begin
            beat_cnt_next = '0;
        end else if (beat_xfer) begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            beat_cnt_reg <= '0;
        end else begin
            beat_cnt_reg <= beat_cnt_next;
        end
    end
`else
    assign limit_hit = 1'b0;
`endif

endmodule
